store_commit_queue: RTL and testbench
=====================================

// Module: store_commit_queue
// PURPOSE
//  Sits directly downstream of the store reservation stations. Captures completed
//  stores (address, data, RB index) and holds them until the reorder buffer commits
//  that RB index. Then writes committed stores to data memory in commit order over a
//  req/ack handshake. Uncommitted stores are discarded on a flush.
// PARAMETERS
//  WORD_SIZE  32  address/data width
//  RB_INDEX   4   width of reorder-buffer index
//  DEPTH      4   number of store slots (power of 2, >=2)
//  SLOT_W     2   log2(DEPTH)
// PORTS
//  clk          in   1          clock, rising edge
//  reset        in   1          asynchronous, active-high
//  st_valid     in   1          one-cycle pulse: a store RS finished
//  st_addr      in   WORD_SIZE  effective address (Vj-Vk from store RS)
//  st_data      in   WORD_SIZE  store data (Vi)
//  st_rb        in   RB_INDEX   RB index of the store
//  commit_valid in   1          one-cycle pulse: ROB commits a store
//  commit_rb    in   RB_INDEX   RB index being committed
//  flush        in   1          squash all uncommitted slots
//  mem_req      out  1          write request to memory
//  mem_addr     out  WORD_SIZE  write address, stable while mem_req=1
//  mem_wdata    out  WORD_SIZE  write data, stable while mem_req=1
//  mem_ack      in   1          memory accepted the write (sampled on clk)
//  full         out  1          all slots occupied (registered); upstream must gate issue
//  empty        out  1          no occupied slots
//  err          out  2          sticky: [0] overflow (st_valid while full), [1] commit miss
// BEHAVIOUR
//  - Reset (async): all slots free, commit FIFO empty, FSM=IDLE, mem_req=0,
//    mem_addr=0, mem_wdata=0, full=0, empty=1, err=0.
//  - Slot state: FREE/WAIT/CMT. On st_valid, the lowest-index FREE slot takes
//    {addr,data,rb} and becomes WAIT. If full=1 at that edge, the store is dropped and
//    err[0] is set, even if a pop happens in the same cycle.
//  - Commit: on commit_valid, the WAIT slot whose rb matches becomes CMT. Its slot
//    number is pushed onto an in-order commit FIFO of depth DEPTH.
//    - A same-cycle st_valid with st_rb==commit_rb is allocated directly as CMT and
//      pushed (bypass).
//    - If no match exists, err[1] is set and nothing changes.
//  - Drain FSM:
//    - IDLE: if the commit FIFO is non-empty, latch the head slot's addr/data into
//      mem_addr/mem_wdata, set mem_req=1, go to REQ.
//    - REQ: hold mem_req and all data stable. When mem_ack=1 at an edge: pop the FIFO,
//      free the slot, mem_req=0, go to IDLE. Back-to-back stores have 1 IDLE cycle.
//  - Latency: commit at edge N gives mem_req=1 after edge N+1 (FIFO previously empty).
//  - Drain order is commit (program) order, never arrival order.
//  - flush: every WAIT slot is freed at the edge. CMT slots and any write in flight
//    are kept.
//    - A commit in the same cycle is applied first, so that store survives.
//    - A st_valid in the same cycle is dropped without setting err.
//  - full/empty/err are registered, updated from next-state slot occupancy.
//  - A freed slot is reusable from the next edge.
//  - Reset mid-REQ: mem_req drops immediately (async). Memory must tolerate an
//    abandoned write.
// CONFIGURATION
//  STORE_FWD_EN defined: adds ports ld_addr in WORD_SIZE, fwd_hit out 1, and
//    fwd_data out WORD_SIZE. These are combinational.
//    - fwd_hit=1 when any CMT slot has addr==ld_addr.
//    - fwd_data comes from the youngest matching slot in commit order (incl. the one
//      in REQ).
//    - WAIT slots are never forwarded. fwd_data=0 when no hit.
//  STORE_FWD_EN undefined: no forwarding ports or logic.
// TESTING
//  1 st(addr=0x10,data=0xAA,rb=3); commit rb=3 @N -> mem_req@N+1 addr=0x10 data=0xAA;
//    ack -> empty=1.
//  2 st rb=5 then rb=2; commit 2 then 5 -> memory writes rb2's store before rb5's.
//  3 fill 4 slots, 5th st_valid -> store dropped, err[0]=1, full stays 1.
//  4 st rb=1,rb=4; commit 1; flush with mem_ack held 0 -> rb=1 write still completes
//    after ack, rb=4 slot freed, commit rb=4 later sets err[1].
//  5 st_valid+commit_valid same cycle, rb=7 -> bypass, mem_req after the next edge.
//  6 assert reset while mem_req=1, ack=0 -> mem_req=0 immediately, empty=1, err=0.
//  7 (STORE_FWD_EN) commit 0x20/0x11 then 0x20/0x22; ld_addr=0x20 -> fwd_hit=1,
//    fwd_data=0x22.

Source files
------------

// File: rtl/store_commit_queue.sv
// rtl/store_commit_queue.sv - store slots held until ROB commit, drained to memory in commit order
// Optional load forwarding from committed slots: define STORE_FWD_EN.
module store_commit_queue #(
  parameter int WORD_SIZE = 32,
  parameter int RB_INDEX  = 4,
  parameter int DEPTH     = 4,
  parameter int SLOT_W    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 st_valid,
  input  logic [WORD_SIZE-1:0] st_addr,
  input  logic [WORD_SIZE-1:0] st_data,
  input  logic [RB_INDEX-1:0]  st_rb,
  input  logic                 commit_valid,
  input  logic [RB_INDEX-1:0]  commit_rb,
  input  logic                 flush,
  output logic                 mem_req,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic                 mem_ack,
`ifdef STORE_FWD_EN
  input  logic [WORD_SIZE-1:0] ld_addr,
  output logic                 fwd_hit,
  output logic [WORD_SIZE-1:0] fwd_data,
`endif
  output logic                 full,
  output logic                 empty,
  output logic [1:0]           err
);

  typedef enum logic [1:0] {S_FREE, S_WAIT, S_CMT} slot_state_e;
  typedef enum logic {IDLE, REQ} drain_state_e;

  slot_state_e          slot_st   [DEPTH];
  slot_state_e          slot_st_n [DEPTH];
  logic [WORD_SIZE-1:0] slot_addr [DEPTH];
  logic [WORD_SIZE-1:0] slot_data [DEPTH];
  logic [RB_INDEX-1:0]  slot_rb   [DEPTH];

  logic [SLOT_W-1:0]    cfifo [DEPTH];
  logic [SLOT_W-1:0]    head, tail;
  logic [SLOT_W:0]      count;

  drain_state_e         state_q, state_n;

  logic                 free_found, match_found;
  logic [SLOT_W-1:0]    free_idx, match_idx, push_slot, head_slot;
  logic                 can_alloc, bypass, alloc, push, pop, latch, commit_miss;
  logic                 full_n, empty_n;

  assign head_slot = cfifo[head];

  // Lowest-index free slot, and the waiting slot owned by the committing RB index.
  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    match_found = 1'b0;
    match_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (slot_st[i] == S_FREE) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(i);
      end
      if (slot_st[i] == S_WAIT && slot_rb[i] == commit_rb) begin
        match_found = 1'b1;
        match_idx   = SLOT_W'(i);
      end
    end
  end

  always_comb begin
    can_alloc   = st_valid && !full && free_found;
    bypass      = commit_valid && !match_found && can_alloc && (st_rb == commit_rb);
    // A committed bypass store survives a flush; a plain new store does not.
    alloc       = can_alloc && (!flush || bypass);
    push        = commit_valid && (match_found || bypass);
    push_slot   = match_found ? match_idx : free_idx;
    commit_miss = commit_valid && !push;
  end

  always_comb begin
    state_n = state_q;
    latch   = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          latch   = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          pop     = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Commit is applied before flush so a same-cycle committed store is kept.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) slot_st_n[i] = slot_st[i];
    if (pop) slot_st_n[head_slot] = S_FREE;
    if (commit_valid && match_found) slot_st_n[match_idx] = S_CMT;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++)
        if (slot_st_n[i] == S_WAIT) slot_st_n[i] = S_FREE;
    end
    if (alloc) slot_st_n[free_idx] = bypass ? S_CMT : S_WAIT;
    full_n  = 1'b1;
    empty_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_st_n[i] == S_FREE) full_n  = 1'b0;
      else                        empty_n = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      err       <= 2'b00;
      for (int i = 0; i < DEPTH; i++) slot_st[i] <= S_FREE;
    end else begin
      state_q <= state_n;
      for (int i = 0; i < DEPTH; i++) slot_st[i] <= slot_st_n[i];
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (latch) begin
        mem_addr  <= slot_addr[head_slot];
        mem_wdata <= slot_data[head_slot];
      end
      full  <= full_n;
      empty <= empty_n;
      err   <= err | {commit_miss, st_valid && full};
    end
  end

  // Payload and FIFO storage carry no reset; slot state gates their use.
  always_ff @(posedge clk) begin
    if (alloc) begin
      slot_addr[free_idx] <= st_addr;
      slot_data[free_idx] <= st_data;
      slot_rb[free_idx]   <= st_rb;
    end
    if (push) cfifo[tail] <= push_slot;
  end

  assign mem_req = (state_q == REQ);

`ifdef STORE_FWD_EN
  // Walk the commit FIFO oldest to youngest so the youngest match wins.
  always_comb begin
    logic [SLOT_W-1:0] s;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    s        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      s = cfifo[SLOT_W'(head + SLOT_W'(i))];
      if (i < int'(count) && slot_st[s] == S_CMT && slot_addr[s] == ld_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = slot_data[s];
      end
    end
  end
`endif

endmodule

// File: tb/tb_store_commit_queue.sv
// tb/tb_store_commit_queue.sv - directed self-checking bench for store_commit_queue
module tb_store_commit_queue;
  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid, commit_valid, flush, mem_ack;
  logic [31:0] st_addr, st_data;
  logic [3:0]  st_rb, commit_rb;
  logic        mem_req, full, empty;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  err;
`ifdef STORE_FWD_EN
  logic [31:0] ld_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  store_commit_queue dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_rb(st_rb),
    .commit_valid(commit_valid), .commit_rb(commit_rb), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
`ifdef STORE_FWD_EN
    .ld_addr(ld_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
`endif
    .full(full), .empty(empty), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one edge, then drop all single-cycle pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    st_valid = 1'b0; commit_valid = 1'b0; flush = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] rb);
    st_valid = 1'b1; st_addr = a; st_data = d; st_rb = rb;
  endtask

  task automatic commit(input logic [3:0] rb);
    commit_valid = 1'b1; commit_rb = rb;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    st_valid = 0; commit_valid = 0; flush = 0; mem_ack = 0;
    st_addr = 0; st_data = 0; st_rb = 0; commit_rb = 0;
`ifdef STORE_FWD_EN
    ld_addr = 0;
`endif
    reset = 1'b1;
    #12;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_err", err, 0);
    reset = 1'b0;
    tick();

    // 1: single store, commit at edge N, request after N+1
    store(32'h10, 32'hAA, 4'd3); tick();
    chk("t1_empty_after_st", empty, 0);
    commit(4'd3); tick();
    chk("t1_req_at_N", mem_req, 0);
    tick();
    chk("t1_req_N1", mem_req, 1);
    chk("t1_addr", mem_addr, 32'h10);
    chk("t1_data", mem_wdata, 32'hAA);
    mem_ack = 1'b1; tick();
    chk("t1_req_after_ack", mem_req, 0);
    chk("t1_empty_after_ack", empty, 1);

    // 2: drain follows commit order, not arrival order
    store(32'h50, 32'h55, 4'd5); tick();
    store(32'h20, 32'h22, 4'd2); tick();
    commit(4'd2); tick();
    commit(4'd5); tick();
    chk("t2_req_first", mem_req, 1);
    chk("t2_addr_first", mem_addr, 32'h20);
    chk("t2_data_first", mem_wdata, 32'h22);
    mem_ack = 1'b1; tick();
    chk("t2_idle_gap", mem_req, 0);
    tick();
    chk("t2_req_second", mem_req, 1);
    chk("t2_addr_second", mem_addr, 32'h50);
    chk("t2_data_second", mem_wdata, 32'h55);
    mem_ack = 1'b1; tick();
    chk("t2_empty", empty, 1);
    chk("t2_err", err, 0);

    // 3: overflow drops the fifth store
    do_reset();
    for (int i = 0; i < 4; i++) begin
      store(32'h100 + 32'(i), 32'h1000 + 32'(i), 4'(8 + i));
      tick();
    end
    chk("t3_full", full, 1);
    chk("t3_err_before", err, 0);
    store(32'h200, 32'h2000, 4'd12); tick();
    chk("t3_err_ovf", err, 2'b01);
    chk("t3_full_stays", full, 1);
    commit(4'd12); tick();
    chk("t3_dropped_miss", err, 2'b11);
    chk("t3_no_req", mem_req, 0);

    // 4: flush keeps committed/in-flight store, frees waiting one
    do_reset();
    store(32'h100, 32'h1, 4'd1); tick();
    store(32'h400, 32'h4, 4'd4); tick();
    commit(4'd1); tick();
    tick();
    chk("t4_req", mem_req, 1);
    flush = 1'b1; tick();
    chk("t4_req_held", mem_req, 1);
    chk("t4_addr_held", mem_addr, 32'h100);
    chk("t4_data_held", mem_wdata, 32'h1);
    chk("t4_not_empty", empty, 0);
    chk("t4_not_full", full, 0);
    mem_ack = 1'b1; tick();
    chk("t4_req_done", mem_req, 0);
    chk("t4_empty", empty, 1);
    commit(4'd4); tick();
    chk("t4_miss", err, 2'b10);
    tick();
    chk("t4_no_req", mem_req, 0);

    // 5: bypass store+commit in one cycle
    store(32'h70, 32'h77, 4'd7); commit(4'd7); tick();
    chk("t5_req_at_N", mem_req, 0);
    chk("t5_empty", empty, 0);
    chk("t5_err_unchanged", err, 2'b10);
    tick();
    chk("t5_req", mem_req, 1);
    chk("t5_addr", mem_addr, 32'h70);
    chk("t5_data", mem_wdata, 32'h77);

    // 6: asynchronous reset while a request is outstanding
    #2;
    reset = 1'b1;
    #1;
    chk("t6_req_async", mem_req, 0);
    chk("t6_empty", empty, 1);
    chk("t6_err", err, 0);
    reset = 1'b0;
    tick();
    chk("t6_req_stays_low", mem_req, 0);

`ifdef STORE_FWD_EN
    // 7: youngest committed store to an address is forwarded
    store(32'h20, 32'h11, 4'd1); commit(4'd1); tick();
    store(32'h20, 32'h22, 4'd2); commit(4'd2); tick();
    store(32'h30, 32'h33, 4'd3); tick();
    ld_addr = 32'h20; #1;
    chk("t7_hit", fwd_hit, 1);
    chk("t7_data", fwd_data, 32'h22);
    ld_addr = 32'h30; #1;
    chk("t7_wait_no_hit", fwd_hit, 0);
    chk("t7_wait_no_data", fwd_data, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
